// File: rtl/apb_pkg.sv
// Shared APB master definitions: bus geometry, FSM state encoding and
// the address-to-slave decode helper.
package apb_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned N          = 4;
    localparam int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } apb_state_e;

    // Raw slave-index field; callers compare against N to catch decode holes.
    function automatic int unsigned apb_slv_idx(input logic [ADDR_WIDTH-1:0] addr,
                                                input int unsigned           sel_lsb);
        logic [ADDR_WIDTH-1:0] shifted;
        shifted = addr >> sel_lsb;
        return 32'(shifted[IDX_W-1:0]);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; expired flags TIMEOUT ready-less cycles.
// A TIMEOUT of 0 disables expiry entirely.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command stream in, SETUP/ACCESS transfer
// on one of N slaves, one response out. Hung slaves are cut off by a timer.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [N-1:0]          p_sel,
    output logic                  p_enable,
    output logic                  p_write,
    output logic [ADDR_WIDTH-1:0] p_addr,
    output logic [DATA_WIDTH-1:0] p_wdata,
    input  logic [N*DATA_WIDTH-1:0] p_rdata,
    input  logic [N-1:0]          p_ready,
    input  logic [N-1:0]          p_slverr
);

    apb_state_e            state, state_d;
    logic [IDX_W-1:0]      slv_idx, slv_idx_d;
    logic                  cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [N-1:0]          p_sel_d;
    logic                  p_enable_d, p_write_d;
    logic [ADDR_WIDTH-1:0] p_addr_d;
    logic [DATA_WIDTH-1:0] p_wdata_d;

    int unsigned           cmd_idx;
    logic                  sel_ready, sel_slverr;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timer_clear, timer_enable, timer_expired;

    // Only the addressed slave's handshake is ever looked at.
    assign sel_ready  = p_ready[slv_idx];
    assign sel_slverr = p_slverr[slv_idx];
    assign sel_rdata  = p_rdata[slv_idx*DATA_WIDTH +: DATA_WIDTH];

    assign timer_clear  = (state == S_SETUP);
    assign timer_enable = (state == S_ACCESS) && !sel_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (pclk),
        .rst     (preset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Every output is a register; the comb process computes its next value.
    always_comb begin
        state_d     = state;
        slv_idx_d   = slv_idx;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        p_sel_d     = p_sel;
        p_enable_d  = p_enable;
        p_write_d   = p_write;
        p_addr_d    = p_addr;
        p_wdata_d   = p_wdata;
        cmd_idx     = apb_slv_idx(cmd_addr, SEL_LSB);

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_idx >= N) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = S_SETUP;
                        slv_idx_d = IDX_W'(cmd_idx);
                        p_sel_d   = N'(1) << IDX_W'(cmd_idx);
                        p_write_d = cmd_write;
                        p_addr_d  = cmd_addr;
                        p_wdata_d = cmd_wdata;
                    end
                end
            end
            S_SETUP: begin
                state_d    = S_ACCESS;
                p_enable_d = 1'b1;
            end
            S_ACCESS: begin
                // Ready in the same cycle as expiry counts as a normal completion.
                if (sel_ready || timer_expired) begin
                    state_d     = S_RESP;
                    p_sel_d     = '0;
                    p_enable_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (sel_ready) begin
                        rsp_err_d   = sel_slverr;
                        rsp_rdata_d = (!p_write && !sel_slverr) ? sel_rdata : '0;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= S_IDLE;
            slv_idx   <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            p_sel     <= '0;
            p_enable  <= 1'b0;
            p_write   <= 1'b0;
            p_addr    <= '0;
            p_wdata   <= '0;
        end else begin
            state     <= state_d;
            slv_idx   <= slv_idx_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            p_sel     <= p_sel_d;
            p_enable  <= p_enable_d;
            p_write   <= p_write_d;
            p_addr    <= p_addr_d;
            p_wdata   <= p_wdata_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait, wait states, slave error,
// timeout and its boundary, response backpressure and mid-ACCESS reset.
module tb_apb_master;
    import apb_pkg::*;

    logic                    pclk = 1'b0;
    logic                    preset;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic [N-1:0]            p_sel;
    logic                    p_enable;
    logic                    p_write;
    logic [ADDR_WIDTH-1:0]   p_addr;
    logic [DATA_WIDTH-1:0]   p_wdata;
    logic [N*DATA_WIDTH-1:0] p_rdata;
    logic [N-1:0]            p_ready;
    logic [N-1:0]            p_slverr;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    always #5 pclk = ~pclk;

    apb_master #(
        .SEL_LSB (12),
        .TIMEOUT (16)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .p_sel     (p_sel),
        .p_enable  (p_enable),
        .p_write   (p_write),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_rdata   (p_rdata),
        .p_ready   (p_ready),
        .p_slverr  (p_slverr)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".rsp_err"},   64'(rsp_err),   64'd0);
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, ".p_sel"},     64'(p_sel),     64'd0);
        check({tag, ".p_enable"},  64'(p_enable),  64'd0);
        check({tag, ".p_write"},   64'(p_write),   64'd0);
        check({tag, ".p_addr"},    64'(p_addr),    64'd0);
        check({tag, ".p_wdata"},   64'(p_wdata),   64'd0);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".done_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        p_rdata   = '0;
        p_ready   = '0;
        p_slverr  = '0;
        step();
        step();
        preset = 1'b0;
        step();
        check_reset_values("reset");

        // Zero-wait write to slave 1; its read data must not leak into the response.
        p_ready = 4'b0010;
        p_rdata[1*32 +: 32] = 32'h5555_5555;
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        check("wr.setup_sel",    64'(p_sel),     64'h2);
        check("wr.setup_en",     64'(p_enable),  64'd0);
        check("wr.setup_write",  64'(p_write),   64'd1);
        check("wr.setup_addr",   64'(p_addr),    64'h1004);
        check("wr.setup_wdata",  64'(p_wdata),   64'hDEAD_BEEF);
        check("wr.setup_cready", 64'(cmd_ready), 64'd0);
        step();
        check("wr.access_sel",   64'(p_sel),     64'h2);
        check("wr.access_en",    64'(p_enable),  64'd1);
        check("wr.access_rv",    64'(rsp_valid), 64'd0);
        step();
        check("wr.rsp_valid",    64'(rsp_valid), 64'd1);
        check("wr.rsp_err",      64'(rsp_err),   64'd0);
        check("wr.rsp_rdata",    64'(rsp_rdata), 64'd0);
        check("wr.rsp_sel",      64'(p_sel),     64'd0);
        check("wr.rsp_en",       64'(p_enable),  64'd0);
        handshake("wr");
        p_ready = '0;

        // Read from slave 3, ready on the 3rd ACCESS cycle; slave 0 noise is ignored.
        p_ready  = 4'b0001;
        p_slverr = 4'b0001;
        p_rdata[0*32 +: 32] = 32'hAAAA_AAAA;
        p_rdata[3*32 +: 32] = 32'h1234_5678;
        issue(1'b0, 32'h0000_3010, 32'h0);
        check("rd.setup_sel",   64'(p_sel),     64'h8);
        check("rd.setup_write", 64'(p_write),   64'd0);
        check("rd.setup_addr",  64'(p_addr),    64'h3010);
        step();
        check("rd.acc1_en",     64'(p_enable),  64'd1);
        check("rd.acc1_rv",     64'(rsp_valid), 64'd0);
        step();
        check("rd.acc2_en",     64'(p_enable),  64'd1);
        check("rd.acc2_rv",     64'(rsp_valid), 64'd0);
        step();
        p_ready = 4'b1001;
        check("rd.acc3_sel",    64'(p_sel),     64'h8);
        check("rd.acc3_addr",   64'(p_addr),    64'h3010);
        check("rd.acc3_write",  64'(p_write),   64'd0);
        check("rd.acc3_rv",     64'(rsp_valid), 64'd0);
        step();
        check("rd.rsp_valid",   64'(rsp_valid), 64'd1);
        check("rd.rsp_rdata",   64'(rsp_rdata), 64'h1234_5678);
        check("rd.rsp_err",     64'(rsp_err),   64'd0);
        handshake("rd");
        p_ready  = '0;
        p_slverr = '0;

        // Slave 2 error on a read: error flag set, read data forced to zero.
        p_ready  = 4'b0100;
        p_slverr = 4'b0100;
        p_rdata[2*32 +: 32] = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_2000, 32'h0);
        check("err.setup_sel",  64'(p_sel),     64'h4);
        step();
        step();
        check("err.rsp_valid",  64'(rsp_valid), 64'd1);
        check("err.rsp_err",    64'(rsp_err),   64'd1);
        check("err.rsp_rdata",  64'(rsp_rdata), 64'd0);
        handshake("err");
        p_ready  = '0;
        p_slverr = '0;

        // Timeout: slave 0 never ready, response 19 cycles after accept.
        p_rdata[0*32 +: 32] = 32'h7777_7777;
        issue(1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 17; i++) step();
        check("to.t18_rv",      64'(rsp_valid), 64'd0);
        check("to.t18_en",      64'(p_enable),  64'd1);
        step();
        check("to.rsp_valid",   64'(rsp_valid), 64'd1);
        check("to.rsp_err",     64'(rsp_err),   64'd1);
        check("to.rsp_rdata",   64'(rsp_rdata), 64'd0);
        check("to.sel_off",     64'(p_sel),     64'd0);
        check("to.en_off",      64'(p_enable),  64'd0);
        handshake("to");

        // Follow-up command after a timeout completes normally.
        p_ready = 4'b0001;
        issue(1'b1, 32'h0000_0008, 32'h0BAD_C0DE);
        check("post.setup_sel", 64'(p_sel),     64'h1);
        step();
        step();
        check("post.rsp_valid", 64'(rsp_valid), 64'd1);
        check("post.rsp_err",   64'(rsp_err),   64'd0);
        handshake("post");
        p_ready = '0;

        // Ready in the very cycle the counter hits the limit wins.
        p_rdata[0*32 +: 32] = 32'h600D_F00D;
        issue(1'b0, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 17; i++) step();
        p_ready = 4'b0001;
        check("edge.t18_rv",    64'(rsp_valid), 64'd0);
        step();
        check("edge.rsp_valid", 64'(rsp_valid), 64'd1);
        check("edge.rsp_err",   64'(rsp_err),   64'd0);
        check("edge.rsp_rdata", 64'(rsp_rdata), 64'h600D_F00D);
        handshake("edge");
        p_ready = '0;

        // Backpressure: response held while a new command waits.
        p_ready = 4'b0010;
        p_rdata[1*32 +: 32] = 32'h0;
        issue(1'b0, 32'h0000_1000, 32'h0);
        step();
        step();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_2004;
        cmd_wdata = 32'h1357_9BDF;
        for (int i = 0; i < 5; i++) begin
            check("bp.rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp.rsp_err",   64'(rsp_err),   64'd0);
            check("bp.cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp.p_sel",     64'(p_sel),     64'd0);
            check("bp.p_addr",    64'(p_addr),    64'h1000);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp.hs_valid",    64'(rsp_valid), 64'd0);
        check("bp.hs_ready",    64'(cmd_ready), 64'd1);
        check("bp.hs_sel",      64'(p_sel),     64'd0);
        step();
        cmd_valid = 1'b0;
        check("bp.new_sel",     64'(p_sel),     64'h4);
        check("bp.new_addr",    64'(p_addr),    64'h2004);
        check("bp.new_wdata",   64'(p_wdata),   64'h1357_9BDF);
        p_ready = 4'b0100;
        step();
        step();
        check("bp.new_rv",      64'(rsp_valid), 64'd1);
        handshake("bp");
        p_ready = '0;

        // Reset during ACCESS discards the transfer.
        issue(1'b1, 32'h0000_1000, 32'hFFFF_0000);
        step();
        check("rst.access_en",  64'(p_enable),  64'd1);
        preset = 1'b1;
        step();
        preset = 1'b0;
        check_reset_values("rst");
        step();
        step();
        check("rst.no_rsp",     64'(rsp_valid), 64'd0);
        check("rst.idle_ready", 64'(cmd_ready), 64'd1);
        check("rst.no_bus",     64'(p_sel),     64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB master that turns a valid/ready command stream into APB SETUP/ACCESS transfers on the shared `apb_interface` bus and returns one response per command. It is the stage directly upstream of the APB slaves: it decodes the address to one of `N` one-hot `p_sel` lines and drives `p_enable`, `p_write`, `p_addr` and `p_wdata`. It muxes the selected slave's `p_rdata`, `p_ready` and `p_slverr` back. A bounded wait-state timeout keeps a hung slave from stalling the command source.

## Interface
- `ADDR_WIDTH`, 32, APB address width (from `apb_pkg`).
- `DATA_WIDTH`, 32, APB data width (from `apb_pkg`).
- `N`, 4, number of slaves / `p_sel` lines (from `apb_pkg`).
- `SEL_LSB`, 12, LSB of the slave-index field in the address; index = `addr[SEL_LSB +: $clog2(N)]`.
- `TIMEOUT`, 16, maximum ACCESS cycles without `p_ready`; 0 disables the timeout.

- `pclk` in 1: clock; all logic is on the rising edge.
- `preset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_WIDTH`: transfer address.
- `cmd_wdata` in `DATA_WIDTH`: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out `DATA_WIDTH`: read data; 0 for writes and errors.
- `rsp_err` out 1: slave error, decode error or timeout.
- `p_sel` out `N`: one-hot slave select.
- `p_enable` out 1: ACCESS phase.
- `p_write` out 1: direction.
- `p_addr` out `ADDR_WIDTH`: address.
- `p_wdata` out `DATA_WIDTH`: write data.
- `p_rdata` in `N`×`DATA_WIDTH`: per-slave read data.
- `p_ready` in `N`: per-slave ready.
- `p_slverr` in `N`: per-slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch write/addr/wdata and compute the slave index.
  - If the index is ≥ `N`: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No bus activity occurs.
  - Otherwise go to SETUP.
- **SETUP**
  - `p_sel[idx]`=1 and `p_enable`=0; `p_addr`, `p_write` and `p_wdata` are driven.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `p_sel[idx]`=1 and `p_enable`=1. Address, data and direction stay stable.
  - Only `p_ready[idx]` and `p_slverr[idx]` are observed; other slaves' inputs are ignored.
  - When `p_ready[idx]`=1: capture `rsp_err`=`p_slverr[idx]`. Capture `rsp_rdata`=`p_rdata[idx]` only for a read without error; otherwise 0. Go to RESP.
  - Wait counter: cleared on entry, incremented each ACCESS cycle without ready.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without ready: deassert the bus, set `rsp_err`=1 and `rsp_rdata`=0, go to RESP.
- **RESP**
  - `rsp_valid`=1; `p_sel` and `p_enable` are 0.
  - Hold `rsp_*` stable until `rsp_ready`, then go to IDLE.
- `cmd_ready` is 0 outside IDLE. There is exactly one command in flight.
- `p_addr`, `p_write` and `p_wdata` keep their last values outside transfers.
- Mid-operation `preset` aborts immediately:
  - FSM returns to IDLE.
  - All outputs take their reset values.
  - The in-flight response is discarded.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `p_sel`=0, `p_enable`=0, `p_write`=0, `p_addr`=0, `p_wdata`=0.
- Command accepted at edge T:
  - SETUP is visible in cycle T+1 and ACCESS in T+2.
  - With zero wait states, `rsp_valid` rises at T+3.
  - Each wait state adds 1 cycle.
- Timeout: `rsp_valid` rises `TIMEOUT`+3 cycles after accept. A `p_ready` that arrives in the same cycle the counter hits the limit wins: normal completion.
- Decode error: `rsp_valid` at T+1.
- Throughput: with `rsp_ready` held high, minimum 4 cycles per transfer. IDLE lasts ≥1 cycle between transfers.

## Structure
- `apb_pkg` holds:
  - `ADDR_WIDTH`, `DATA_WIDTH` and `N`.
  - The FSM state enum `apb_state_e`.
  - Address-decode helper function `apb_slv_idx`.
- Sub-module `apb_wait_timer`: the wait counter with clear, enable and `expired` outputs, parameterised by `TIMEOUT`.

## Test plan
- **Zero-wait write**
  - Stimulus: write 0x0000_1004 / 0xDEAD_BEEF; slave 1 `p_ready` tied high.
  - Response: `p_sel`=4'b0010, SETUP then ACCESS, `rsp_valid` at T+3, `rsp_err`=0, `rsp_rdata`=0.
- **Read with wait states**
  - Stimulus: read 0x0000_3010; slave 3 asserts `p_ready` on the 3rd ACCESS cycle with `p_rdata`=0x1234_5678.
  - Response: `rsp_rdata`=0x1234_5678, `rsp_valid` at T+5. Bus signals stable throughout ACCESS.
- **Slave error**
  - Stimulus: read with `p_slverr[2]`=1 at ready.
  - Response: `rsp_err`=1, `rsp_rdata`=0.
- **Timeout**
  - Stimulus: slave never ready, `TIMEOUT`=16.
  - Response: `rsp_err`=1 at T+19, `p_sel`=0 afterwards. Then issue a second command and check it completes normally.
- **Backpressure**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles while a new `cmd_valid` is pending.
  - Response: `rsp_*` stable, `cmd_ready`=0, no bus activity until the handshake.
- **Reset mid-ACCESS**
  - Stimulus: assert `preset` during ACCESS.
  - Response: next cycle all outputs at reset values, `cmd_ready`=1, no response emitted.
